// File: rtl/switch_debounce_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_debounce_edge: sync + settle-time debounce, rise/fall strobes,    |
// | wrapping press counter; optional long-press strobe (LONG_PRESS_EN).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module switch_debounce_edge #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int COUNT_W        = 8,
  parameter int LONG_LIMIT     = 25000000
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Switch,
  output logic               o_Switch,
  output logic               o_Rise,
  output logic               o_Fall,
  output logic [COUNT_W-1:0] o_Count,
  output logic               o_Long
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(DEBOUNCE_LIMIT - 1);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_t;

  logic          meta;
  logic          sync;
  state_t        state;
  logic [CW-1:0] settle;
  logic          rise_ok;
  logic          fall_ok;

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_LIMIT + 1);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_LIMIT);
  localparam logic [HW-1:0] LONG_M1  = HW'(LONG_LIMIT - 1);
  logic [HW-1:0] hold;
`else
  // Constant 0 for every legal LONG_LIMIT; keeps the parameter referenced.
  assign o_Long = (LONG_LIMIT < 1);
`endif

  // A limit of 1 accepts straight from the stable states, skipping the waits.
  always_comb begin
    rise_ok = 1'b0;
    fall_ok = 1'b0;
    if (sync) begin
      rise_ok = ((state == S_LOW) && (DEBOUNCE_LIMIT == 1)) ||
                ((state == S_RISE_WAIT) && (settle == LIMIT_M1));
    end else begin
      fall_ok = ((state == S_HIGH) && (DEBOUNCE_LIMIT == 1)) ||
                ((state == S_FALL_WAIT) && (settle == LIMIT_M1));
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      state    <= S_LOW;
      settle   <= '0;
      o_Switch <= 1'b0;
      o_Rise   <= 1'b0;
      o_Fall   <= 1'b0;
      o_Count  <= '0;
`ifdef LONG_PRESS_EN
      hold     <= '0;
      o_Long   <= 1'b0;
`endif
    end else begin
      meta   <= i_Switch;
      sync   <= meta;
      o_Rise <= 1'b0;
      o_Fall <= 1'b0;
      if (rise_ok) begin
        state    <= S_HIGH;
        settle   <= '0;
        o_Switch <= 1'b1;
        o_Rise   <= 1'b1;
        o_Count  <= o_Count + COUNT_W'(1);
      end else if (fall_ok) begin
        state    <= S_LOW;
        settle   <= '0;
        o_Switch <= 1'b0;
        o_Fall   <= 1'b1;
      end else begin
        case (state)
          S_LOW: begin
            if (sync) begin
              state  <= S_RISE_WAIT;
              settle <= CW'(1);
            end
          end
          S_RISE_WAIT: begin
            if (!sync) begin
              state  <= S_LOW;
              settle <= '0;
            end else begin
              settle <= settle + CW'(1);
            end
          end
          S_HIGH: begin
            if (!sync) begin
              state  <= S_FALL_WAIT;
              settle <= CW'(1);
            end
          end
          S_FALL_WAIT: begin
            if (sync) begin
              state  <= S_HIGH;
              settle <= '0;
            end else begin
              settle <= settle + CW'(1);
            end
          end
          default: begin
            state  <= S_LOW;
            settle <= '0;
          end
        endcase
      end
`ifdef LONG_PRESS_EN
      // Only an accepted rise clears the hold count; a fall-side bounce does not.
      o_Long <= 1'b0;
      if (rise_ok) begin
        hold <= '0;
      end else if ((state == S_HIGH) || (state == S_FALL_WAIT)) begin
        if (hold != LONG_MAX) hold <= hold + HW'(1);
        if (hold == LONG_M1) o_Long <= 1'b1;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_edge.sv
`default_nettype none
// Bench for switch_debounce_edge: directed steps plus random bounce, checked
// against a sample-history reference model.
module tb_switch_debounce_edge;

  localparam int LIM = 4;
  localparam int CWID = 3;
  localparam int LL = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            sw;
  logic            dut_sw;
  logic            dut_rise;
  logic            dut_fall;
  logic [CWID-1:0] dut_cnt;
  logic            dut_long;

  int total = 0;
  int bad = 0;

  // reference model state
  logic pipe[$];
  logic hist[$];
  logic m_lvl;
  logic m_rise;
  logic m_fall;
  logic m_long;
  int   m_cnt;
  int   m_age;

  switch_debounce_edge #(
    .DEBOUNCE_LIMIT(LIM),
    .COUNT_W(CWID),
    .LONG_LIMIT(LL)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .i_Switch(sw),
    .o_Switch(dut_sw),
    .o_Rise(dut_rise),
    .o_Fall(dut_fall),
    .o_Count(dut_cnt),
    .o_Long(dut_long)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe = {1'b0, 1'b0};
    hist = {};
    m_lvl = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_long = 1'b0;
    m_cnt = 0; m_age = 0;
  endtask

  // Level flips once the last LIM samples seen past the 2-flop delay all
  // disagree with the current level.
  task automatic model_edge(input logic in);
    logic seen;
    logic pre;
    logic flip;
    seen = pipe.pop_front();
    pipe.push_back(in);
    hist.push_back(seen);
    if (hist.size() > LIM) void'(hist.pop_front());
    pre = m_lvl;
    flip = (hist.size() == LIM);
    foreach (hist[k]) if (hist[k] == pre) flip = 1'b0;
    m_rise = flip && !pre;
    m_fall = flip && pre;
    if (flip) m_lvl = !pre;
    if (m_rise) m_cnt = (m_cnt + 1) % (1 << CWID);
    m_long = 1'b0;
    if (m_rise) m_age = 0;
    else if (pre) begin
      m_age++;
`ifdef LONG_PRESS_EN
      m_long = (m_age == LL);
`endif
    end
  endtask

  task automatic step(input logic s, input logic r);
    sw = s;
    rst = r;
    @(posedge clk);
    if (r) model_reset();
    else model_edge(s);
    #1;
    chk("level", int'(dut_sw), int'(m_lvl));
    chk("rise", int'(dut_rise), int'(m_rise));
    chk("fall", int'(dut_fall), int'(m_fall));
    chk("count", int'(dut_cnt), m_cnt);
    chk("long", int'(dut_long), int'(m_long));
  endtask

  initial begin
    int first;
    int seen_long;
    logic v;
    sw = 1'b0;
    rst = 1'b1;
    model_reset();

    // reset with a toggling pin, then idle low
    for (int i = 0; i < 3; i++) step(i[0], 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

    // clean press: level at 6th edge after the step
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0);
      if (dut_rise && first == 0) first = i;
    end
    chk("rise_latency", first, LIM + 2);
    chk("count_after_press", int'(dut_cnt), 1);

    // short low dip while held high: no fall
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("dip_no_fall", int'(dut_sw), 1);

    // release: fall at 6th edge, count stays
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0);
      if (dut_fall && first == 0) first = i;
    end
    chk("fall_latency", first, LIM + 2);
    chk("count_after_release", int'(dut_cnt), 1);

    // short high glitch while low: nothing
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk("glitch_no_rise", int'(dut_cnt), 1);

    // seven more presses wrap the 3-bit counter
    for (int p = 0; p < 7; p++) begin
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    end
    chk("count_wrap", int'(dut_cnt), 0);

    // reset mid-settle while held high
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("rst_mid_level", int'(dut_sw), 0);
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0);
      if (dut_rise && first == 0) first = i;
    end
    chk("rst_rise_latency", first, LIM + 2);
    chk("rst_count", int'(dut_cnt), 1);

    // long hold, then a second long hold
    seen_long = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0);
      seen_long += int'(dut_long);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      seen_long += int'(dut_long);
    end
`ifdef LONG_PRESS_EN
    chk("long_pulses", seen_long, 2);
`else
    chk("long_pulses", seen_long, 0);
`endif

    // random bouncing with occasional resets
    for (int n = 0; n < 150; n++) begin
      v = $urandom_range(0, 1) == 1;
      first = $urandom_range(1, 8);
      for (int i = 0; i < first; i++) step(v, $urandom_range(0, 60) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
